// File: rtl/traceback_prefetch_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : traceback_prefetch_scheduler_if
//  Description : Bundle of the request, memory, finder and response signals
//                around the traceback prefetch scheduler.
//                  slave  : the scheduler itself
//                  master : requesters, direction memory, column finder and
//                           response consumer
//  Revision    : 1.0 - initial release
// ============================================================================
interface traceback_prefetch_scheduler_if #(
    parameter int N               = 8,
    parameter int LOG_N           = 3,
    parameter int DIRECTION_WIDTH = 2,
    parameter int POSITION_WIDTH  = 12,
    parameter int PREFETCH_LENGTH = 4
);
    // requesters
    logic                                    cur_req_valid;
    logic                                    cur_req_ready;
    logic [POSITION_WIDTH-1:0]               cur_req_x;
    logic [POSITION_WIDTH-1:0]               cur_req_y;
    logic                                    pf_req_valid;
    logic                                    pf_req_ready;
    logic [POSITION_WIDTH-1:0]               pf_req_x;
    logic [POSITION_WIDTH-1:0]               pf_req_y;
    // direction memory read port
    logic                                    mem_rd_en;
    logic [POSITION_WIDTH-1:0]               mem_rd_y;
    logic [POSITION_WIDTH-LOG_N-1:0]         mem_rd_blk_k0;
    logic [POSITION_WIDTH-LOG_N-1:0]         mem_rd_blk_k1;
    logic [N*DIRECTION_WIDTH-1:0]            mem_col_k0;
    logic [N*DIRECTION_WIDTH-1:0]            mem_col_k1;
    // column finder
    logic [N*DIRECTION_WIDTH-1:0]            column_k0;
    logic [N*DIRECTION_WIDTH-1:0]            column_k1;
    logic [1:0]                              prefetch_request;
    logic [POSITION_WIDTH-1:0]               in_block_x_startpoint;
    logic [POSITION_WIDTH-1:0]               prefetch_x_startpoint;
    logic [PREFETCH_LENGTH*DIRECTION_WIDTH-1:0] prefetch_column;
    // response
    logic                                    rsp_valid;
    logic                                    rsp_ready;
    logic [1:0]                              rsp_tag;
    logic [PREFETCH_LENGTH*DIRECTION_WIDTH-1:0] rsp_column;
    logic                                    busy;

    modport slave (
        input  cur_req_valid, cur_req_x, cur_req_y,
        input  pf_req_valid, pf_req_x, pf_req_y,
        output cur_req_ready, pf_req_ready,
        output mem_rd_en, mem_rd_y, mem_rd_blk_k0, mem_rd_blk_k1,
        input  mem_col_k0, mem_col_k1,
        output column_k0, column_k1, prefetch_request,
        output in_block_x_startpoint, prefetch_x_startpoint,
        input  prefetch_column,
        output rsp_valid, rsp_tag, rsp_column, busy,
        input  rsp_ready
    );

    modport master (
        output cur_req_valid, cur_req_x, cur_req_y,
        output pf_req_valid, pf_req_x, pf_req_y,
        input  cur_req_ready, pf_req_ready,
        input  mem_rd_en, mem_rd_y, mem_rd_blk_k0, mem_rd_blk_k1,
        output mem_col_k0, mem_col_k1,
        input  column_k0, column_k1, prefetch_request,
        input  in_block_x_startpoint, prefetch_x_startpoint,
        output prefetch_column,
        input  rsp_valid, rsp_tag, rsp_column, busy,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/traceback_prefetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : traceback_prefetch_scheduler
//  Description : Arbitrates the traceback direction memory read port and the
//                prefetch column finder between the current-position engine
//                (fixed priority) and the lookahead prefetcher. One
//                transaction in flight: IDLE -> READ -> WAIT -> SELECT -> RESP.
//  Ports       : clk, reset (synchronous, active high)
//                bus (slave modport of traceback_prefetch_scheduler_if):
//                  cur_req_* / pf_req_*   request handshakes + positions
//                  mem_rd_* / mem_col_*   memory read strobe, address, data
//                  column_k*, prefetch_request, *_startpoint -> finder
//                  prefetch_column        <- finder
//                  rsp_*                  tagged segment response
//                  busy                   FSM not idle
//  Options     : `define PREFETCH_REUSE_EN to skip the memory read when a
//                grant hits the (y, blk) of the last completed read.
//  Revision    : 1.0 - initial release
// ============================================================================
module traceback_prefetch_scheduler #(
    parameter int N               = 8,
    parameter int LOG_N           = 3,
    parameter int DIRECTION_WIDTH = 2,
    parameter int POSITION_WIDTH  = 12,
    parameter int PREFETCH_LENGTH = 4,
    parameter int MEM_LATENCY     = 1
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    traceback_prefetch_scheduler_if.slave bus
);

    localparam int C_BLK_W  = POSITION_WIDTH - LOG_N;
    localparam int C_WORD_W = N * DIRECTION_WIDTH;
    localparam int C_SEG_W  = PREFETCH_LENGTH * DIRECTION_WIDTH;
    localparam int C_CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [C_BLK_W-1:0] C_BLK_MAX  = '1;
    localparam logic [C_CNT_W-1:0] C_LAT_LAST = C_CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] C_TAG_CUR = 2'b01;
    localparam logic [1:0] C_TAG_PF  = 2'b10;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_READ   = 3'd1;
    localparam logic [2:0] C_ST_WAIT   = 3'd2;
    localparam logic [2:0] C_ST_SELECT = 3'd3;
    localparam logic [2:0] C_ST_RESP   = 3'd4;

    logic [2:0]                r_state;
    logic [C_CNT_W-1:0]        r_lat_cnt;
    logic                      r_mem_rd_en;
    logic [POSITION_WIDTH-1:0] r_mem_rd_y;
    logic [C_BLK_W-1:0]        r_mem_rd_blk_k0;
    logic [C_BLK_W-1:0]        r_mem_rd_blk_k1;
    logic [C_WORD_W-1:0]       r_column_k0;
    logic [C_WORD_W-1:0]       r_column_k1;
    logic [1:0]                r_prefetch_request;
    logic [POSITION_WIDTH-1:0] r_in_block_x_startpoint;
    logic [POSITION_WIDTH-1:0] r_prefetch_x_startpoint;
    logic                      r_rsp_valid;
    logic [1:0]                r_rsp_tag;
    logic [C_SEG_W-1:0]        r_rsp_column;

    logic                      w_idle;
    logic                      w_cur_grant;
    logic                      w_pf_grant;
    logic                      w_grant;
    logic [POSITION_WIDTH-1:0] w_grant_x;
    logic [POSITION_WIDTH-1:0] w_grant_y;
    logic [C_BLK_W-1:0]        w_grant_blk;
    logic                      w_reuse_hit;
    logic                      w_k1_past_edge;

    // Fixed-priority arbitration, only while idle.
    assign w_idle      = (r_state == C_ST_IDLE);
    assign w_cur_grant = w_idle && bus.cur_req_valid;
    assign w_pf_grant  = w_idle && !bus.cur_req_valid && bus.pf_req_valid;
    assign w_grant     = w_cur_grant || w_pf_grant;
    assign w_grant_x   = bus.cur_req_valid ? bus.cur_req_x : bus.pf_req_x;
    assign w_grant_y   = bus.cur_req_valid ? bus.cur_req_y : bus.pf_req_y;
    assign w_grant_blk = w_grant_x[POSITION_WIDTH-1:LOG_N];

    // The last block of a row has no right-hand neighbour; its k1 word reads
    // as all-zero directions.
    assign w_k1_past_edge = (r_mem_rd_blk_k0 == C_BLK_MAX);

`ifdef PREFETCH_REUSE_EN
    logic                      r_rec_valid;
    logic [POSITION_WIDTH-1:0] r_rec_y;
    logic [C_BLK_W-1:0]        r_rec_blk;

    // column_k* still hold the words of the recorded read, so a hit can go
    // straight to the finder.
    assign w_reuse_hit = r_rec_valid && (r_rec_y == w_grant_y) && (r_rec_blk == w_grant_blk);
`else
    assign w_reuse_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                 <= C_ST_IDLE;
            r_lat_cnt               <= '0;
            r_mem_rd_en             <= 1'b0;
            r_mem_rd_y              <= '0;
            r_mem_rd_blk_k0         <= '0;
            r_mem_rd_blk_k1         <= '0;
            r_column_k0             <= '0;
            r_column_k1             <= '0;
            r_prefetch_request      <= 2'b00;
            r_in_block_x_startpoint <= '0;
            r_prefetch_x_startpoint <= '0;
            r_rsp_valid             <= 1'b0;
            r_rsp_tag               <= 2'b00;
            r_rsp_column            <= '0;
`ifdef PREFETCH_REUSE_EN
            r_rec_valid             <= 1'b0;
            r_rec_y                 <= '0;
            r_rec_blk               <= '0;
`endif
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_grant) begin
                        r_prefetch_request <= w_cur_grant ? C_TAG_CUR : C_TAG_PF;
                        r_rsp_tag          <= w_cur_grant ? C_TAG_CUR : C_TAG_PF;
                        if (w_cur_grant) begin
                            r_in_block_x_startpoint <= w_grant_x;
                        end else begin
                            r_prefetch_x_startpoint <= w_grant_x;
                        end
                        r_mem_rd_y      <= w_grant_y;
                        r_mem_rd_blk_k0 <= w_grant_blk;
                        r_mem_rd_blk_k1 <= (w_grant_blk == C_BLK_MAX) ? w_grant_blk
                                                                      : w_grant_blk + C_BLK_W'(1);
                        if (w_reuse_hit) begin
                            r_state <= C_ST_SELECT;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_state     <= C_ST_READ;
                        end
                    end
                end
                C_ST_READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_lat_cnt   <= '0;
                    r_state     <= C_ST_WAIT;
                end
                C_ST_WAIT: begin
                    // Data is valid MEM_LATENCY cycles after the read strobe,
                    // i.e. in the last WAIT cycle.
                    if (r_lat_cnt == C_LAT_LAST) begin
                        r_column_k0 <= bus.mem_col_k0;
                        r_column_k1 <= w_k1_past_edge ? '0 : bus.mem_col_k1;
`ifdef PREFETCH_REUSE_EN
                        r_rec_valid <= 1'b1;
                        r_rec_y     <= r_mem_rd_y;
                        r_rec_blk   <= r_mem_rd_blk_k0;
`endif
                        r_state     <= C_ST_SELECT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + C_CNT_W'(1);
                    end
                end
                C_ST_SELECT: begin
                    r_rsp_column <= bus.prefetch_column;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= C_ST_RESP;
                end
                C_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid        <= 1'b0;
                        r_prefetch_request <= 2'b00;
                        r_state            <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cur_req_ready         = w_idle;
    assign bus.pf_req_ready          = w_idle && !bus.cur_req_valid;
    assign bus.mem_rd_en             = r_mem_rd_en;
    assign bus.mem_rd_y              = r_mem_rd_y;
    assign bus.mem_rd_blk_k0         = r_mem_rd_blk_k0;
    assign bus.mem_rd_blk_k1         = r_mem_rd_blk_k1;
    assign bus.column_k0             = r_column_k0;
    assign bus.column_k1             = r_column_k1;
    assign bus.prefetch_request      = r_prefetch_request;
    assign bus.in_block_x_startpoint = r_in_block_x_startpoint;
    assign bus.prefetch_x_startpoint = r_prefetch_x_startpoint;
    assign bus.rsp_valid             = r_rsp_valid;
    assign bus.rsp_tag               = r_rsp_tag;
    assign bus.rsp_column            = r_rsp_column;
    assign bus.busy                  = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_traceback_prefetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traceback_prefetch_scheduler
//  Description : Self-checking bench for traceback_prefetch_scheduler with a
//                latency-1 direction memory model, a column finder model and
//                a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traceback_prefetch_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    traceback_prefetch_scheduler_if bus ();

    traceback_prefetch_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [1:0] tag;
        logic [7:0] col;
    } exp_t;

    exp_t sb[$];

    // ---------------- reference functions ----------------
    function automatic logic [15:0] mem_word(input logic [11:0] y, input logic [8:0] blk);
        logic [15:0] a;
        logic [15:0] b;
        a = {4'd0, y} * 16'h9E37;
        b = {7'd0, blk} * 16'h7F4B;
        return a ^ b ^ 16'h5A5A;
    endfunction

    function automatic logic [7:0] seg(input logic [15:0] k0, input logic [15:0] k1, input logic [2:0] xl);
        logic [31:0] cat;
        cat = {k1, k0};
        return cat[int'(xl)*2 +: 8];
    endfunction

    function automatic logic [7:0] exp_col(input logic [11:0] x, input logic [11:0] y);
        logic [8:0]  b;
        logic [15:0] k1;
        b  = x[11:3];
        k1 = (b == 9'h1FF) ? 16'h0000 : mem_word(y, b + 9'd1);
        return seg(mem_word(y, b), k1, x[2:0]);
    endfunction

    // ---------------- memory model (latency 1) ----------------
    logic        md_valid;
    logic [15:0] md0;
    logic [15:0] md1;

    always @(posedge clk) begin
        md_valid <= bus.mem_rd_en;
        md0      <= mem_word(bus.mem_rd_y, bus.mem_rd_blk_k0);
        md1      <= mem_word(bus.mem_rd_y, bus.mem_rd_blk_k1);
    end

    assign bus.mem_col_k0 = (md_valid === 1'b1) ? md0 : 16'hF0F0;
    assign bus.mem_col_k1 = (md_valid === 1'b1) ? md1 : 16'h0F0F;

    // ---------------- column finder model ----------------
    always_comb begin
        bus.prefetch_column = seg(bus.column_k0, bus.column_k1,
                                  (bus.prefetch_request == 2'b10) ? bus.prefetch_x_startpoint[2:0]
                                                                  : bus.in_block_x_startpoint[2:0]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for rsp_valid; n = cycles waited, -1 on timeout.
    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        if (bus.rsp_valid !== 1'b1) n = -1;
    endtask

    // Samples the response, completes the handshake, leaves the bench in the
    // first cycle after it.
    task automatic handshake(output logic [1:0] tag, output logic [7:0] col);
        tag = bus.rsp_tag;
        col = bus.rsp_column;
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.prefetch_request !== 2'b00) begin bad++; $display("FAIL reset_pfreq got=%b want=00", bus.prefetch_request); end
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.mem_rd_en); end
        total++; if (bus.column_k0 !== 16'h0) begin bad++; $display("FAIL reset_col_k0 got=%h want=0", bus.column_k0); end
        reset = 1'b0;
        cycle();
        total++; if (bus.cur_req_ready !== 1'b1) begin bad++; $display("FAIL idle_cur_ready got=%b want=1", bus.cur_req_ready); end
    endtask

    task automatic test_basic();
        int n; exp_t e; logic [1:0] tg; logic [7:0] cl;
        bus.cur_req_x = 12'd13; bus.cur_req_y = 12'd5; bus.cur_req_valid = 1'b1;
        #1;
        total++; if (bus.cur_req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", bus.cur_req_ready); end
        sb.push_back(exp_t'{tag: 2'b01, col: exp_col(12'd13, 12'd5)});
        cycle(); bus.cur_req_valid = 1'b0;          // t+1
        total++; if (bus.mem_rd_en !== 1'b1) begin bad++; $display("FAIL basic_rd_en got=%b want=1", bus.mem_rd_en); end
        total++; if (bus.mem_rd_y !== 12'd5) begin bad++; $display("FAIL basic_rd_y got=%0d want=5", bus.mem_rd_y); end
        total++; if (bus.mem_rd_blk_k0 !== 9'd1 || bus.mem_rd_blk_k1 !== 9'd2) begin bad++; $display("FAIL basic_blk got=%0d/%0d want=1/2", bus.mem_rd_blk_k0, bus.mem_rd_blk_k1); end
        total++; if (bus.prefetch_request !== 2'b01) begin bad++; $display("FAIL basic_pfreq_t1 got=%b want=01", bus.prefetch_request); end
        cycle();                                    // t+2
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL basic_rd_en_t2 got=%b want=0", bus.mem_rd_en); end
        cycle();                                    // t+3
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early_rsp got=%b want=0", bus.rsp_valid); end
        wait_rsp(n);                                // expect t+4
        total++; if (n !== 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", n); end
        total++; if (bus.prefetch_request !== 2'b01) begin bad++; $display("FAIL basic_pfreq_t4 got=%b want=01", bus.prefetch_request); end
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag) begin bad++; $display("FAIL basic_tag got=%b want=%b", tg, e.tag); end
        total++; if (cl !== e.col) begin bad++; $display("FAIL basic_col got=%h want=%h", cl, e.col); end
        total++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.prefetch_request !== 2'b00) begin
            bad++; $display("FAIL basic_after_hs got=%b/%b/%b want=0/0/00", bus.rsp_valid, bus.busy, bus.prefetch_request); end
    endtask

    task automatic test_priority();
        int n; exp_t e; logic [1:0] tg; logic [7:0] cl;
        bus.cur_req_x = 12'd20; bus.cur_req_y = 12'd7; bus.cur_req_valid = 1'b1;
        bus.pf_req_x  = 12'd33; bus.pf_req_y  = 12'd9; bus.pf_req_valid  = 1'b1;
        #1;
        total++; if (bus.cur_req_ready !== 1'b1 || bus.pf_req_ready !== 1'b0) begin
            bad++; $display("FAIL prio_ready got=%b/%b want=1/0", bus.cur_req_ready, bus.pf_req_ready); end
        sb.push_back(exp_t'{tag: 2'b01, col: exp_col(12'd20, 12'd7)});
        cycle(); bus.cur_req_valid = 1'b0;
        wait_rsp(n);
        total++; if (n !== 3) begin bad++; $display("FAIL prio_cur_latency got=%0d want=3", n); end
        total++; if (bus.pf_req_ready !== 1'b0) begin bad++; $display("FAIL prio_pf_ready_hs got=%b want=0", bus.pf_req_ready); end
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag || cl !== e.col) begin bad++; $display("FAIL prio_cur_rsp got=%b/%h want=%b/%h", tg, cl, e.tag, e.col); end
        total++; if (bus.pf_req_ready !== 1'b1) begin bad++; $display("FAIL prio_pf_ready_idle got=%b want=1", bus.pf_req_ready); end
        sb.push_back(exp_t'{tag: 2'b10, col: exp_col(12'd33, 12'd9)});
        cycle(); bus.pf_req_valid = 1'b0;
        total++; if (bus.prefetch_request !== 2'b10) begin bad++; $display("FAIL prio_pfreq got=%b want=10", bus.prefetch_request); end
        total++; if (bus.prefetch_x_startpoint !== 12'd33 || bus.in_block_x_startpoint !== 12'd20) begin
            bad++; $display("FAIL prio_startpoints got=%0d/%0d want=33/20", bus.prefetch_x_startpoint, bus.in_block_x_startpoint); end
        total++; if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_y !== 12'd9 || bus.mem_rd_blk_k0 !== 9'd4) begin
            bad++; $display("FAIL prio_pf_read got=%b/%0d/%0d want=1/9/4", bus.mem_rd_en, bus.mem_rd_y, bus.mem_rd_blk_k0); end
        wait_rsp(n);
        total++; if (n !== 3) begin bad++; $display("FAIL prio_pf_latency got=%0d want=3", n); end
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag || cl !== e.col) begin bad++; $display("FAIL prio_pf_rsp got=%b/%h want=%b/%h", tg, cl, e.tag, e.col); end
    endtask

    task automatic test_backpressure();
        int n; exp_t e; logic [1:0] tg; logic [7:0] cl; logic [1:0] t0; logic [7:0] c0;
        bus.cur_req_x = 12'd50; bus.cur_req_y = 12'd3; bus.cur_req_valid = 1'b1;
        #1;
        sb.push_back(exp_t'{tag: 2'b01, col: exp_col(12'd50, 12'd3)});
        cycle(); bus.cur_req_valid = 1'b0; bus.cur_req_x = 12'd999;   // late change is ignored
        wait_rsp(n);
        total++; if (n !== 3) begin bad++; $display("FAIL bp_latency got=%0d want=3", n); end
        t0 = bus.rsp_tag; c0 = bus.rsp_column;
        bus.pf_req_x = 12'd60; bus.pf_req_y = 12'd8; bus.pf_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== t0 || bus.rsp_column !== c0 ||
                bus.cur_req_ready !== 1'b0 || bus.pf_req_ready !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got v=%b tag=%b col=%h crdy=%b prdy=%b rd=%b want v=1 tag=%b col=%h crdy=0 prdy=0 rd=0",
                         i, bus.rsp_valid, bus.rsp_tag, bus.rsp_column, bus.cur_req_ready, bus.pf_req_ready, bus.mem_rd_en, t0, c0);
            end
        end
        bus.pf_req_valid = 1'b0;
        #1;
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag || cl !== e.col) begin bad++; $display("FAIL bp_rsp got=%b/%h want=%b/%h", tg, cl, e.tag, e.col); end
    endtask

    task automatic test_edge_block();
        int n; exp_t e; logic [1:0] tg; logic [7:0] cl;
        bus.cur_req_x = 12'd4095; bus.cur_req_y = 12'd11; bus.cur_req_valid = 1'b1;
        #1;
        sb.push_back(exp_t'{tag: 2'b01, col: exp_col(12'd4095, 12'd11)});
        cycle(); bus.cur_req_valid = 1'b0;
        total++; if (bus.mem_rd_blk_k0 !== 9'd511 || bus.mem_rd_blk_k1 !== 9'd511) begin
            bad++; $display("FAIL edge_blk got=%0d/%0d want=511/511", bus.mem_rd_blk_k0, bus.mem_rd_blk_k1); end
        wait_rsp(n);
        total++; if (n !== 3) begin bad++; $display("FAIL edge_latency got=%0d want=3", n); end
        total++; if (bus.column_k1 !== 16'h0000) begin bad++; $display("FAIL edge_col_k1 got=%h want=0000", bus.column_k1); end
        total++; if (bus.column_k0 !== mem_word(12'd11, 9'd511)) begin
            bad++; $display("FAIL edge_col_k0 got=%h want=%h", bus.column_k0, mem_word(12'd11, 9'd511)); end
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag || cl !== e.col) begin bad++; $display("FAIL edge_rsp got=%b/%h want=%b/%h", tg, cl, e.tag, e.col); end
    endtask

    task automatic test_reset_mid();
        bus.cur_req_x = 12'd100; bus.cur_req_y = 12'd2; bus.cur_req_valid = 1'b1;
        #1;
        cycle(); bus.cur_req_valid = 1'b0;          // READ
        cycle(); reset = 1'b1;                      // WAIT, memory data present
        cycle(); reset = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.prefetch_request !== 2'b00) begin
            bad++; $display("FAIL rstmid_state got=%b/%b/%b want=0/0/00", bus.busy, bus.rsp_valid, bus.prefetch_request); end
        total++; if (bus.mem_rd_en !== 1'b0 || bus.mem_rd_y !== 12'd0 || bus.in_block_x_startpoint !== 12'd0) begin
            bad++; $display("FAIL rstmid_regs got=%b/%0d/%0d want=0/0/0", bus.mem_rd_en, bus.mem_rd_y, bus.in_block_x_startpoint); end
        total++; if (bus.column_k0 !== 16'h0 || bus.column_k1 !== 16'h0) begin
            bad++; $display("FAIL rstmid_cols got=%h/%h want=0/0", bus.column_k0, bus.column_k1); end
        cycle(); cycle();
        total++; if (bus.column_k0 !== 16'h0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_late got=%h/%b want=0/0", bus.column_k0, bus.busy); end
    endtask

    task automatic test_reuse();
        int n; int exp_lat; logic exp_rd; exp_t e; logic [1:0] tg; logic [7:0] cl;
`ifdef PREFETCH_REUSE_EN
        exp_lat = 1; exp_rd = 1'b0;
`else
        exp_lat = 3; exp_rd = 1'b1;
`endif
        bus.cur_req_x = 12'd13; bus.cur_req_y = 12'd5; bus.cur_req_valid = 1'b1;
        #1;
        sb.push_back(exp_t'{tag: 2'b01, col: exp_col(12'd13, 12'd5)});
        cycle(); bus.cur_req_valid = 1'b0;
        total++; if (bus.mem_rd_en !== 1'b1) begin bad++; $display("FAIL reuse_first_rd got=%b want=1", bus.mem_rd_en); end
        wait_rsp(n);
        total++; if (n !== 3) begin bad++; $display("FAIL reuse_first_latency got=%0d want=3", n); end
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag || cl !== e.col) begin bad++; $display("FAIL reuse_first_rsp got=%b/%h want=%b/%h", tg, cl, e.tag, e.col); end
        bus.pf_req_x = 12'd10; bus.pf_req_y = 12'd5; bus.pf_req_valid = 1'b1;
        #1;
        sb.push_back(exp_t'{tag: 2'b10, col: exp_col(12'd10, 12'd5)});
        cycle(); bus.pf_req_valid = 1'b0;
        total++; if (bus.mem_rd_en !== exp_rd) begin bad++; $display("FAIL reuse_rd_en got=%b want=%b", bus.mem_rd_en, exp_rd); end
        wait_rsp(n);
        total++; if (n !== exp_lat) begin bad++; $display("FAIL reuse_latency got=%0d want=%0d", n, exp_lat); end
        handshake(tg, cl);
        e = sb.pop_front();
        total++; if (tg !== e.tag || cl !== e.col) begin bad++; $display("FAIL reuse_pf_rsp got=%b/%h want=%b/%h", tg, cl, e.tag, e.col); end
    endtask

    initial begin
        reset             = 1'b1;
        bus.cur_req_valid = 1'b0;
        bus.cur_req_x     = '0;
        bus.cur_req_y     = '0;
        bus.pf_req_valid  = 1'b0;
        bus.pf_req_x      = '0;
        bus.pf_req_y      = '0;
        bus.rsp_ready     = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_backpressure();
        test_edge_block();
        test_reset_mid();
        test_reuse();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/traceback_prefetch_scheduler.md
Name: traceback_prefetch_scheduler

Overview:
Arbitrates the shared traceback direction memory read port and prefetch column finder between two requesters: the current-position traceback engine and the lookahead prefetcher. It issues memory reads for adjacent column blocks and registers the returned words. It drives the finder's request code and startpoints, then returns the selected PREFETCH_LENGTH-entry segment to the granted requester with a tag. One transaction is in flight at a time.

Parameters:
N, 8, columns per memory word (power of 2)
LOG_N, 3, log2(N)
DIRECTION_WIDTH, 2, bits per direction entry
POSITION_WIDTH, 12, x/y coordinate width
PREFETCH_LENGTH, 4, entries per returned segment (<= N)
MEM_LATENCY, 1, cycles from mem_rd_en to valid mem_col_* (>= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cur_req_valid / cur_req_ready  in/out  1  current-position request handshake
cur_req_x, cur_req_y  in  POSITION_WIDTH  current position
pf_req_valid / pf_req_ready  in/out  1  prefetch request handshake
pf_req_x, pf_req_y  in  POSITION_WIDTH  prefetch position
mem_rd_en  out  1  one-cycle read strobe
mem_rd_y  out  POSITION_WIDTH  row address
mem_rd_blk_k0, mem_rd_blk_k1  out  POSITION_WIDTH-LOG_N  block addresses
mem_col_k0, mem_col_k1  in  N*DIRECTION_WIDTH  memory read data
column_k0, column_k1  out  N*DIRECTION_WIDTH  registered words to finder
prefetch_request  out  2  finder select: 01 current, 10 prefetch, 00 idle
in_block_x_startpoint, prefetch_x_startpoint  out  POSITION_WIDTH  finder startpoints
prefetch_column  in  PREFETCH_LENGTH*DIRECTION_WIDTH  finder output
rsp_valid / rsp_ready  out/in  1  response handshake
rsp_tag  out  2  01 current, 10 prefetch
rsp_column  out  PREFETCH_LENGTH*DIRECTION_WIDTH  returned segment
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE -> READ -> WAIT -> SELECT -> RESP -> IDLE.
- Reset, including reset asserted mid-operation, forces IDLE. It zeroes all registered outputs, column_k*, rsp_*, startpoints, prefetch_request and mem_rd_*. It also clears the latency counter and reuse-valid flag. Memory data returning after reset is never captured.
- Arbitration is combinational, in IDLE only.
  - cur_req_ready = (state==IDLE).
  - pf_req_ready = (state==IDLE) & !cur_req_valid.
  - Current has fixed priority; prefetch may starve by design.
- Grant in cycle t (valid & ready):
  - Latch x, y and tag.
  - Granted x goes to in_block_x_startpoint (current) or prefetch_x_startpoint (prefetch); the other startpoint holds its value.
  - prefetch_request = tag from t+1 until return to IDLE.
- Address generation: blk = x >> LOG_N; mem_rd_blk_k0 = blk; mem_rd_blk_k1 = blk+1. When blk is all-ones, mem_rd_blk_k1 = blk and column_k1 is loaded as zero.
- READ, cycle t+1: mem_rd_en=1, mem_rd_y=y. mem_rd_en is 0 in all other states.
- WAIT counts MEM_LATENCY. In cycle t+1+MEM_LATENCY, mem_col_* is registered into column_k0/k1 (k1 zero-gated as above).
- SELECT, cycle t+2+MEM_LATENCY: the finder output is stable and rsp_column <= prefetch_column.
- RESP, from t+3+MEM_LATENCY (t+4 for MEM_LATENCY=1):
  - rsp_valid=1; rsp_tag and rsp_column are held stable until rsp_ready.
  - The handshake cycle returns the FSM to IDLE, where rsp_valid=0.
  - No new grant occurs in the handshake cycle; the next grant is at the earliest one cycle later.
- Requester inputs are sampled only at grant; later changes are ignored.

Optional Feature:
PREFETCH_REUSE_EN.
- Defined:
  - The scheduler records (y, blk) of the last completed memory read, with a valid flag.
  - A granted request matching the record skips READ/WAIT: IDLE -> SELECT. column_k* are retained, no mem_rd_en, rsp_valid at t+2.
  - The flag is cleared on reset.
- Undefined: every grant performs a memory read.

Test Plan:
1. MEM_LATENCY=1, cur x=13 y=5 granted at t -> mem_rd_en at t+1 with y=5, blk_k0=1, blk_k1=2. rsp_valid at t+4, rsp_tag=01, rsp_column equals the finder output for x_low=5, prefetch_request=01 during t+1..t+4.
2. cur and pf both valid at t -> cur_req_ready=1, pf_req_ready=0. pf is granted in the first IDLE cycle after the cur response handshake; its rsp_tag=10 and prefetch_x_startpoint = pf x.
3. rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_tag and rsp_column are stable. Both req_ready signals stay 0 and there is no mem_rd_en.
4. cur x=4095 (blk=511) -> mem_rd_blk_k1=511, column_k1 all zero, column_k0 = memory data.
5. reset asserted in WAIT -> next cycle IDLE, busy=0, rsp_valid=0, prefetch_request=00. Memory data arriving afterwards is not captured.
6. cur x=13 y=5 completes, then pf x=10 y=5 -> with PREFETCH_REUSE_EN: no mem_rd_en, rsp_valid at t+2. Without it: mem_rd_en at t+1, rsp_valid at t+4.
